mux_nx1_pipe: RTL and testbench

- Parametrised N-channel, WIDTH-bit selector built as a log2(N)-level tree of 2:1 mux stages.
- Each tree level is registered, so throughput is one word per clock.
- Valid/ready handshake on both sides, with whole-pipeline stall on output backpressure.
- Optional auto-scan mode steps the channel select round-robin on every accepted transfer; used where a channel is picked dynamically rather than by a static select.

---
 rtl/mux_nx1_pipe.sv | 102 ++++++++++
 tb/tb_mux_nx1_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_pipe.sv
// rtl/mux_nx1_pipe.sv - pipelined N:1 channel selector tree with valid/ready and round-robin auto-scan
module mux_nx1_pipe #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 auto_scan,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // The tree halves the word count per level, so anything but a power of two breaks it.
    if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
        $error("mux_nx1_pipe: N must be a power of two and at least 2");
    end

    logic             w_stall;
    logic             w_accept;
    logic [SEL_W-1:0] w_eff_sel;
    logic [SEL_W-1:0] r_scan_cnt;

    // Output backpressure freezes the whole pipe; upstream sees it the same cycle.
    assign w_stall   = out_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign w_accept  = in_valid & in_ready;
    assign w_eff_sel = auto_scan ? r_scan_cnt : in_sel;

    // Round-robin channel pointer; advances only on words it actually picked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
        end else if (w_accept && auto_scan) begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Level k holds N>>(k+1) words plus the full select of the word they belong to;
    // bit k of that carried select steers the pair-wise mux feeding level k.
    for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
        logic [SEL_W-1:0] r_sel;
        logic             r_valid;
        logic [SEL_W-1:0] w_sel_in;
        logic             w_valid_in;

        if (k == 0) begin : g_src
            assign w_sel_in   = w_eff_sel;
            assign w_valid_in = w_accept;
        end else begin : g_src
            assign w_sel_in   = g_lvl[k-1].r_sel;
            assign w_valid_in = g_lvl[k-1].r_valid;
        end

        // Valid always advances (bubbles included); select only follows real words.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_sel   <= '0;
            end else if (!w_stall) begin
                r_valid <= w_valid_in;
                if (w_valid_in) begin
                    r_sel <= w_sel_in;
                end
            end
        end

        for (genvar j = 0; j < (N >> (k + 1)); j++) begin : g_w
            logic [WIDTH-1:0] w_lo;
            logic [WIDTH-1:0] w_hi;
            logic [WIDTH-1:0] r_data;

            if (k == 0) begin : g_mux
                assign w_lo = in_data[(2*j)*WIDTH +: WIDTH];
                assign w_hi = in_data[(2*j+1)*WIDTH +: WIDTH];
            end else begin : g_mux
                assign w_lo = g_lvl[k-1].g_w[2*j].r_data;
                assign w_hi = g_lvl[k-1].g_w[2*j+1].r_data;
            end

            // Data loads only with a valid word so the last level keeps its value across bubbles.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data <= '0;
                end else if (!w_stall && w_valid_in) begin
                    r_data <= w_sel_in[k] ? w_hi : w_lo;
                end
            end
        end
    end

    assign out_data  = g_lvl[SEL_W-1].g_w[0].r_data;
    assign out_sel   = g_lvl[SEL_W-1].r_sel;
    assign out_valid = g_lvl[SEL_W-1].r_valid;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// tb/tb_mux_nx1_pipe.sv - self-checking bench for mux_nx1_pipe (N=4 main, N=2 and N=8 latency)
module tb_mux_nx1_pipe;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SEL_W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [N*WIDTH-1:0]   in_data;
    logic [SEL_W-1:0]     in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic                 auto_scan;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_sel;
    logic                 out_valid;
    logic                 out_ready;

    logic [2*WIDTH-1:0]   n2_in_data;
    logic [0:0]           n2_in_sel;
    logic                 n2_in_valid, n2_in_ready, n2_out_valid;
    logic [WIDTH-1:0]     n2_out_data;
    logic [0:0]           n2_out_sel;

    logic [8*WIDTH-1:0]   n8_in_data;
    logic [2:0]           n8_in_sel;
    logic                 n8_in_valid, n8_in_ready, n8_out_valid;
    logic [WIDTH-1:0]     n8_out_data;
    logic [2:0]           n8_out_sel;

    mux_nx1_pipe #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .auto_scan(auto_scan), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_nx1_pipe #(.WIDTH(WIDTH), .N(2)) dut_n2 (
        .clk(clk), .rst(rst), .in_data(n2_in_data), .in_sel(n2_in_sel), .in_valid(n2_in_valid),
        .in_ready(n2_in_ready), .auto_scan(1'b0), .out_data(n2_out_data), .out_sel(n2_out_sel),
        .out_valid(n2_out_valid), .out_ready(1'b1)
    );

    mux_nx1_pipe #(.WIDTH(WIDTH), .N(8)) dut_n8 (
        .clk(clk), .rst(rst), .in_data(n8_in_data), .in_sel(n8_in_sel), .in_valid(n8_in_valid),
        .in_ready(n8_in_ready), .auto_scan(1'b0), .out_data(n8_out_data), .out_sel(n8_out_sel),
        .out_valid(n8_out_valid), .out_ready(1'b1)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a FIFO of expected (data, channel) plus the scan pointer.
    int exp_data_q[$];
    int exp_sel_q[$];
    int m_scan = 0;

    function automatic int pick(input logic [N*WIDTH-1:0] d, input int ch);
        logic [WIDTH-1:0] w;
        w = d[ch*WIDTH +: WIDTH];
        return int'(w);
    endfunction

    function automatic logic [N*WIDTH-1:0] rand_data();
        logic [N*WIDTH-1:0] d;
        d = {$urandom, $urandom};
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model side of an accepted word.
    task automatic model_accept();
        int eff;
        eff = auto_scan ? m_scan : int'(in_sel);
        exp_data_q.push_back(pick(in_data, eff));
        exp_sel_q.push_back(eff);
        if (auto_scan) m_scan = (m_scan + 1) % N;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; auto_scan = 1'b0; out_ready = 1'b1;
        n2_in_valid = 1'b0; n2_in_sel = '0; n2_in_data = '0;
        n8_in_valid = 1'b0; n8_in_sel = '0; n8_in_data = '0;
        #3;
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_assert++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
        n_assert++; if (out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_out_sel got %0d want 0", out_sel); end
        tick();
        rst = 1'b0;
        #2;
        n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_static();
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        in_sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            #3;
            if (t == 0) begin
                n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL static_in_ready got %b want 1", in_ready); end
            end else begin
                n_assert++;
                if (out_valid !== (t == 2)) begin n_fail++; $display("FAIL static_valid_t%0d got %b want %b", t, out_valid, t == 2); end
                if (t == 2) begin
                    n_assert++; if (out_data !== 8'h33) begin n_fail++; $display("FAIL static_data got %h want 33", out_data); end
                    n_assert++; if (out_sel !== 2'd2) begin n_fail++; $display("FAIL static_sel got %0d want 2", out_sel); end
                end
            end
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic test_stream();
        int sels[4] = '{0, 3, 1, 2};
        int wants[4] = '{8'h11, 8'h44, 8'h22, 8'h33};
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 4);
            if (c < 4) in_sel = 2'(sels[c]);
            #3;
            n_assert++;
            if (out_valid !== (c >= 2 && c < 6)) begin n_fail++; $display("FAIL stream_valid_c%0d got %b want %b", c, out_valid, (c >= 2 && c < 6)); end
            if (c >= 2 && c < 6) begin
                n_assert++;
                if (out_data !== 8'(wants[c-2]) || out_sel !== 2'(sels[c-2]))
                    begin n_fail++; $display("FAIL stream_word%0d got %h/%0d want %h/%0d", c-2, out_data, out_sel, wants[c-2], sels[c-2]); end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0;
        logic [WIDTH-1:0] held;
        in_valid = 1'b0;
        held = '0;
        for (int c = 0; c < 20; c++) begin
            if (!in_valid && sent < 4) begin
                in_data = rand_data(); in_sel = 2'($urandom_range(0, 3)); in_valid = 1'b1;
            end
            out_ready = !(c >= 3 && c < 6);
            #3;
            n_assert++;
            if (in_ready !== !(c >= 3 && c < 6)) begin n_fail++; $display("FAIL bp_in_ready_c%0d got %b want %b", c, in_ready, !(c >= 3 && c < 6)); end
            if (c == 3) held = out_data;
            if (c >= 3 && c < 6) begin
                n_assert++;
                if (out_valid !== 1'b1 || out_data !== held) begin n_fail++; $display("FAIL bp_hold_c%0d got %b/%h want 1/%h", c, out_valid, out_data, held); end
            end
            if (in_valid && in_ready) begin model_accept(); sent++; end
            if (out_valid && out_ready) begin
                n_assert++;
                if (exp_data_q.size() == 0) begin n_fail++; $display("FAIL bp_extra_word got %h want none", out_data); end
                else begin
                    int ed, es;
                    ed = exp_data_q.pop_front(); es = exp_sel_q.pop_front();
                    got++;
                    if (out_data !== 8'(ed) || out_sel !== 2'(es)) begin n_fail++; $display("FAIL bp_word%0d got %h/%0d want %h/%0d", got, out_data, out_sel, ed, es); end
                end
            end
            tick();
            if (in_valid && sent > 0 && exp_data_q.size() + got == sent) begin
                if (sent == 4 || in_ready) in_valid = (in_valid && !(exp_data_q.size() + got == sent));
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_assert++; if (got !== 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", got); end
    endtask

    task automatic test_autoscan();
        int seq[10] = '{0, 1, 2, 3, 0, 1, 3, 3, 2, 3};
        in_data = rand_data(); out_ready = 1'b1; in_sel = 2'd3;
        for (int c = 0; c < 13; c++) begin
            in_valid = (c < 10);
            auto_scan = !(c == 6 || c == 7);
            #3;
            if (c >= 2 && c < 12) begin
                n_assert++;
                if (out_valid !== 1'b1 || out_sel !== 2'(seq[c-2]) || out_data !== 8'(pick(in_data, seq[c-2])))
                    begin n_fail++; $display("FAIL scan_word%0d got %b/%0d/%h want 1/%0d/%h", c-2, out_valid, out_sel, out_data, seq[c-2], pick(in_data, seq[c-2])); end
            end
            tick();
        end
        in_valid = 1'b0; auto_scan = 1'b0;
    endtask

    task automatic test_async_reset();
        in_data = rand_data(); auto_scan = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; tick(); tick(); in_valid = 1'b0;
        #3;
        n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid got %b want 1", out_valid); end
        rst = 1'b1;
        #1;
        n_assert++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0)
            begin n_fail++; $display("FAIL areset_outputs got %b/%h/%0d want 0/00/0", out_valid, out_data, out_sel); end
        tick();
        rst = 1'b0;
        m_scan = 0;
        in_data = rand_data(); in_sel = 2'd3; in_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            #3;
            if (t > 0) begin
                n_assert++;
                if (out_valid !== (t == 2)) begin n_fail++; $display("FAIL areset_valid_t%0d got %b want %b", t, out_valid, t == 2); end
                if (t == 2) begin
                    n_assert++;
                    if (out_sel !== 2'd0 || out_data !== 8'(pick(in_data, 0)))
                        begin n_fail++; $display("FAIL areset_first got %0d/%h want 0/%h", out_sel, out_data, pick(in_data, 0)); end
                end
            end
            tick();
            in_valid = 1'b0;
        end
        m_scan = 1;
        auto_scan = 1'b0;
    endtask

    task automatic test_random();
        logic prev_stall = 1'b0;
        logic [WIDTH-1:0] prev_data = '0;
        logic [SEL_W-1:0] prev_sel = '0;
        exp_data_q.delete(); exp_sel_q.delete();
        in_valid = 1'b0;
        for (int c = 0; c < 110; c++) begin
            if (c < 90) begin
                if (!in_valid) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_data = rand_data(); in_sel = 2'($urandom_range(0, 3));
                end
                if ($urandom_range(0, 4) == 0) auto_scan = ~auto_scan;
                out_ready = ($urandom_range(0, 9) < 7);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            #3;
            if (prev_stall) begin
                n_assert++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_sel !== prev_sel)
                    begin n_fail++; $display("FAIL rnd_hold_c%0d got %b/%h/%0d want 1/%h/%0d", c, out_valid, out_data, out_sel, prev_data, prev_sel); end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data; prev_sel = out_sel;
            if (in_valid && in_ready) model_accept();
            if (out_valid && out_ready) begin
                n_assert++;
                if (exp_data_q.size() == 0) begin n_fail++; $display("FAIL rnd_extra_word got %h want none", out_data); end
                else begin
                    int ed, es;
                    ed = exp_data_q.pop_front(); es = exp_sel_q.pop_front();
                    if (out_data !== 8'(ed) || out_sel !== 2'(es)) begin n_fail++; $display("FAIL rnd_word_c%0d got %h/%0d want %h/%0d", c, out_data, out_sel, ed, es); end
                end
            end
            tick();
            if (in_valid && in_ready) in_valid = 1'b0;
        end
        n_assert++;
        if (exp_data_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain got %0d pending want 0", exp_data_q.size()); end
        auto_scan = 1'b0;
    endtask

    task automatic test_n2();
        for (int ch = 0; ch < 2; ch++) begin
            n2_in_data = 16'($urandom); n2_in_sel = 1'(ch); n2_in_valid = 1'b1;
            for (int t = 0; t < 3; t++) begin
                #3;
                if (t > 0) begin
                    n_assert++;
                    if (n2_out_valid !== (t == 1)) begin n_fail++; $display("FAIL n2_valid_ch%0d_t%0d got %b want %b", ch, t, n2_out_valid, t == 1); end
                    if (t == 1) begin
                        n_assert++;
                        if (n2_out_data !== n2_in_data[ch*8 +: 8] || n2_out_sel !== 1'(ch))
                            begin n_fail++; $display("FAIL n2_word_ch%0d got %h/%0d want %h/%0d", ch, n2_out_data, n2_out_sel, n2_in_data[ch*8 +: 8], ch); end
                    end
                end
                tick();
                n2_in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_n8();
        for (int ch = 0; ch < 8; ch++) begin
            n8_in_data = {$urandom, $urandom}; n8_in_sel = 3'(ch); n8_in_valid = 1'b1;
            for (int t = 0; t < 5; t++) begin
                #3;
                if (t > 0) begin
                    n_assert++;
                    if (n8_out_valid !== (t == 3)) begin n_fail++; $display("FAIL n8_valid_ch%0d_t%0d got %b want %b", ch, t, n8_out_valid, t == 3); end
                    if (t == 3) begin
                        n_assert++;
                        if (n8_out_data !== n8_in_data[ch*8 +: 8] || n8_out_sel !== 3'(ch))
                            begin n_fail++; $display("FAIL n8_word_ch%0d got %h/%0d want %h/%0d", ch, n8_out_data, n8_out_sel, n8_in_data[ch*8 +: 8], ch); end
                    end
                end
                tick();
                n8_in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_stream();
        test_backpressure();
        test_autoscan();
        test_async_reset();
        test_random();
        test_n2();
        test_n8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
